// File: rtl/mips_pkg.sv
// Shared widths and control-bundle field positions for the
// MIPS-style pipeline stages.
package mips_pkg;

   localparam int XLEN    = 32;
   localparam int REG_W   = 5;
   localparam int ALUOP_W = 7;
   localparam int CTRL_W  = 5 + ALUOP_W;

   // Control bundle layout, MSB first.
   localparam int CTRL_REGWRITE = 11;
   localparam int CTRL_MEMREAD  = 10;
   localparam int CTRL_MEMWRITE = 9;
   localparam int CTRL_MEMTOREG = 8;
   localparam int CTRL_ALUSRC   = 7;
   localparam int CTRL_ALUOP_LO = 0;

   typedef logic [REG_W-1:0] reg_addr_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the load in EX
// and the source operands of the instruction in ID.
module load_use_detect
   import mips_pkg::*;
(
   input  logic      i_valid_ex,
   input  logic      i_memread_ex,
   input  reg_addr_t i_wtaddr_ex,
   input  logic      i_valid_id,
   input  logic      i_uses_rs,
   input  logic      i_uses_rt,
   input  reg_addr_t i_rs_id,
   input  reg_addr_t i_rt_id,
   output logic      o_load_use
);

   logic w_ld_live;
   logic w_rs_hit;
   logic w_rt_hit;

   // $zero is never a real destination, so it can't create a hazard
   assign w_ld_live = i_valid_ex & i_memread_ex
                    & (i_wtaddr_ex != '0) & i_valid_id;
   assign w_rs_hit  = i_uses_rs & (i_rs_id == i_wtaddr_ex);
   assign w_rt_hit  = i_uses_rt & (i_rt_id == i_wtaddr_ex);

   assign o_load_use = w_ld_live & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion,
// branch flush and memory-wait stall handling.
module id_ex_stage #(
   parameter int CTRL_W = mips_pkg::CTRL_W,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Valid_ID,
   input  logic [CTRL_W-1:0] Ctrl_ID,
   input  logic              UsesRs_ID,
   input  logic              UsesRt_ID,
   input  logic [4:0]        Rs_ID,
   input  logic [4:0]        Rt_ID,
   input  logic [4:0]        RegWtaddr_ID,
   input  logic [31:0]       RegRdout1_ID,
   input  logic [31:0]       RegRdout2_ID,
   input  logic [31:0]       Imm_ID,
   input  logic [31:0]       PC_ID,
   input  logic              Flush_EX,
   input  logic              Stall_MEM,
   output logic              Valid_EX,
   output logic [CTRL_W-1:0] Ctrl_EX,
   output logic [4:0]        Rs_EX,
   output logic [4:0]        Rt_EX,
   output logic [4:0]        RegWtaddr_EX,
   output logic [31:0]       RegRdout1_EX,
   output logic [31:0]       RegRdout2_EX,
   output logic [31:0]       Imm_EX,
   output logic [31:0]       PC_EX,
   output logic              Stall_IF_ID,
   output logic [CNT_W-1:0]  BubbleCnt
);

   logic              r_valid;
   logic [CTRL_W-1:0] r_ctrl;
   logic [4:0]        r_rs;
   logic [4:0]        r_rt;
   logic [4:0]        r_wa;
   logic [31:0]       r_d1;
   logic [31:0]       r_d2;
   logic [31:0]       r_imm;
   logic [31:0]       r_pc;
   logic              r_flush_pend;
   logic [CNT_W-1:0]  r_bub_cnt;

   logic w_load_use;
   logic w_flush;
   logic w_cnt_max;

   load_use_detect u_lud (
      .i_valid_ex   (r_valid),
      .i_memread_ex (r_ctrl[mips_pkg::CTRL_MEMREAD]),
      .i_wtaddr_ex  (r_wa),
      .i_valid_id   (Valid_ID),
      .i_uses_rs    (UsesRs_ID),
      .i_uses_rt    (UsesRt_ID),
      .i_rs_id      (Rs_ID),
      .i_rt_id      (Rt_ID),
      .o_load_use   (w_load_use)
   );

   assign w_flush   = Flush_EX | r_flush_pend;
   assign w_cnt_max = &r_bub_cnt;

   // A flush kills the dependent instruction, so no hold is needed
   assign Stall_IF_ID = Stall_MEM | (w_load_use & ~w_flush);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid      <= 1'b0;
         r_ctrl       <= '0;
         r_rs         <= '0;
         r_rt         <= '0;
         r_wa         <= '0;
         r_d1         <= '0;
         r_d2         <= '0;
         r_imm        <= '0;
         r_pc         <= '0;
         r_flush_pend <= 1'b0;
         r_bub_cnt    <= '0;
      end else if (Stall_MEM) begin
         if (Flush_EX)
            r_flush_pend <= 1'b1;
      end else if (w_flush) begin
         r_valid      <= 1'b0;
         r_ctrl       <= '0;
         r_rs         <= '0;
         r_rt         <= '0;
         r_wa         <= '0;
         r_flush_pend <= 1'b0;
      end else if (w_load_use) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
         r_rs    <= '0;
         r_rt    <= '0;
         r_wa    <= '0;
         if (!w_cnt_max)
            r_bub_cnt <= r_bub_cnt + CNT_W'(1);
      end else begin
         r_valid <= Valid_ID;
         r_ctrl  <= Valid_ID ? Ctrl_ID : '0;
         r_rs    <= Rs_ID;
         r_rt    <= Rt_ID;
         r_wa    <= RegWtaddr_ID;
         r_d1    <= RegRdout1_ID;
         r_d2    <= RegRdout2_ID;
         r_imm   <= Imm_ID;
         r_pc    <= PC_ID;
      end
   end

   assign Valid_EX     = r_valid;
   assign Ctrl_EX      = r_ctrl;
   assign Rs_EX        = r_rs;
   assign Rt_EX        = r_rt;
   assign RegWtaddr_EX = r_wa;
   assign RegRdout1_EX = r_d1;
   assign RegRdout2_EX = r_d2;
   assign Imm_EX       = r_imm;
   assign PC_EX        = r_pc;
   assign BubbleCnt    = r_bub_cnt;

endmodule
